treg_pipe: RTL and testbench
============================

TREG_PIPE -- requirements
Module: treg_pipe

Interface
REQ-001 Parameter WIDTH, default 10: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal range 1..16; values outside the range shall fail elaboration.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, synchronous and active-low.
REQ-005 in_valid  input  1: upstream word present on in_data.
REQ-006 in_data  input  WIDTH: upstream word.
REQ-007 in_ready  output  1: pipeline accepts in_data this cycle.
REQ-008 out_valid  output  1: out_data holds a valid word.
REQ-009 out_data  output  WIDTH: data of the last stage.
REQ-010 out_ready  input  1: downstream accepts out_data this cycle.
REQ-011 flush  input  1: synchronous discard of all held words.
REQ-012 occupancy  output  $clog2(DEPTH+1): count of valid stages.

Function
REQ-013 Stage k (0..DEPTH-1) holds a valid bit v[k] and a data register d[k]; stage 0 faces the input and stage DEPTH-1 drives out_valid/out_data.
REQ-014 Stage ready r[k] = !v[k] || r[k+1], with r[DEPTH] = out_ready; ready propagates combinationally so that bubbles collapse.
REQ-015 in_ready shall equal r[0] && !flush.
REQ-016 A transfer occurs on a cycle where valid and ready are both 1 at a boundary; in_data is captured into d[0] on an input transfer.
REQ-017 When r[k+1] is 1: v[k+1] <= v[k] and, if v[k] is 1, d[k+1] <= d[k]; when r[k+1] is 0, stage k+1 holds v and d.
REQ-018 Latency: a word accepted in cycle N appears on out_data in cycle N+DEPTH when out_ready has been held at 1 throughout.
REQ-019 Throughput: one word per cycle sustained while out_ready is 1; no bubble is inserted.
REQ-020 Stall: while out_valid is 1 and out_ready is 0, out_data and out_valid shall be held stable.
REQ-021 Order shall be preserved; no word is duplicated or dropped, except by flush or reset.
REQ-022 flush=1: all v[k] <= 0 at the next edge; in_ready is 0 that cycle, so no input transfer occurs; d registers are not required to change.
REQ-023 An output transfer during a flush cycle is permitted and counts as delivered.
REQ-024 occupancy = number of set v[k], registered, consistent with v at every cycle; maximum value DEPTH (full); in_ready shall be 1 whenever occupancy < DEPTH and flush is 0.
REQ-025 When full and out_ready is 1, an input transfer and an output transfer shall occur in the same cycle and occupancy shall remain DEPTH.
REQ-026 When in_valid is 1 and in_ready is 0, upstream data shall not be captured.

Reset
REQ-027 rst_n=0 at a rising edge: all v[k]=0, all d[k]=0, occupancy=0; hence out_valid=0 and out_data=0 from the next cycle.
REQ-028 Reset has priority over flush and over any transfer; words in flight are discarded.
REQ-029 While rst_n=0, in_ready shall read 0 so that no transfer occurs.

Structure
REQ-030 Shared package treg_pkg shall hold TREG_WIDTH_DEF=10, TREG_DEPTH_DEF=2, and the legal range limits TREG_WIDTH_MAX=64 and TREG_DEPTH_MAX=16.
REQ-031 One sub-module treg_stage (parameter WIDTH; ports: clk, rst_n, flush, up_valid, up_data, dn_ready, up_ready, dn_valid, dn_data) shall be instantiated DEPTH times via generate.
REQ-032 The occupancy counter shall be implemented in treg_pipe as an up/down counter (+1 on input transfer, -1 on output transfer, 0 on flush), not as a popcount.

Verification (WIDTH=10, DEPTH=3)
REQ-033 Reset, then stream 0x001..0x005 on consecutive cycles with out_ready=1 -> the first word appears 3 cycles after acceptance, then one word per cycle in order, occupancy peaks at 3.
REQ-034 out_ready=0, push 0x3FF, 0x155, 0x2AA -> occupancy=3, in_ready=0, out_data held at 0x3FF; raise out_ready -> 0x3FF, 0x155, 0x2AA drain on consecutive cycles.
REQ-035 Full with out_ready=1 and in_valid=1 for 10 cycles -> simultaneous in/out transfers every cycle, occupancy stays 3, no loss.
REQ-036 Occupancy 2, assert flush for 1 cycle with in_valid=1 -> in_ready=0 that cycle, then out_valid=0 and occupancy=0; the flushed words never appear.
REQ-037 Assert rst_n=0 with 2 words in flight and flush=1 -> next cycle out_valid=0, out_data=0x000, occupancy=0, in_ready=0 while held in reset.
REQ-038 Random in_valid/out_ready (50%) for 2000 words -> a scoreboard shows an in-order, lossless match, and occupancy always equals the scoreboard depth.

Source files
------------

// File: rtl/treg_pkg.sv
// Shared constants for the treg register pipeline.
package treg_pkg;
  localparam int TREG_WIDTH_DEF = 10;
  localparam int TREG_DEPTH_DEF = 2;
  localparam int TREG_WIDTH_MAX = 64;
  localparam int TREG_DEPTH_MAX = 16;
endpackage

// File: rtl/treg_stage.sv
// One register stage of the pipeline: a valid bit plus a data register.
// Handshake: a word moves across a boundary on a cycle where the producer's
// valid and the consumer's ready are both 1; ready never depends on valid.
module treg_stage
  import treg_pkg::*;
#(
  parameter int WIDTH = TREG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data
);

  logic             v;
  logic [WIDTH-1:0] d;

  // An empty stage always accepts, so bubbles collapse through the chain.
  assign up_ready = !v || dn_ready;
  assign dn_valid = v;
  assign dn_data  = d;

  // Load from upstream whenever this stage can move; flush only drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (flush) begin
        v <= 1'b0;
      end else if (up_ready) begin
        v <= up_valid;
      end
      if (up_ready && up_valid) begin
        d <= up_data;
      end
    end
  end

endmodule

// File: rtl/treg_pipe.sv
// DEPTH-stage valid/ready register pipeline with flush and an occupancy count.
module treg_pipe
  import treg_pkg::*;
#(
  parameter int WIDTH = TREG_WIDTH_DEF,
  parameter int DEPTH = TREG_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH + 1);

  // Illegal parameter values stop elaboration.
  if (DEPTH < 1 || DEPTH > TREG_DEPTH_MAX) begin : g_bad_depth
    $error("treg_pipe: DEPTH out of range");
  end
  if (WIDTH < 1 || WIDTH > TREG_WIDTH_MAX) begin : g_bad_width
    $error("treg_pipe: WIDTH out of range");
  end

  // Boundary k sits in front of stage k; boundary DEPTH is the output.
  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [WIDTH-1:0] dat [DEPTH+1];

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;

  // Stage chain; stage DEPTH-1 drives the output boundary.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    treg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (vld[k]),
      .up_data  (dat[k]),
      .dn_ready (rdy[k+1]),
      .up_ready (rdy[k]),
      .dn_valid (vld[k+1]),
      .dn_data  (dat[k+1])
    );
  end

  // No input transfer during flush or while reset is asserted.
  assign in_ready  = rdy[0] && !flush && rst_n;
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];

  logic in_xfer;
  logic out_xfer;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Up/down occupancy counter tracking the number of valid stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OW'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: tb/tb_treg_pipe.sv
// Directed and randomised checks for treg_pipe with WIDTH=10, DEPTH=3.
module tb_treg_pipe;
  localparam int W = 10;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;
  logic [1:0]   occupancy;

  int total = 0;
  int bad   = 0;

  // Outputs sampled on the falling edge of the most recent cycle.
  logic         s_ir;
  logic         s_ov;
  logic [W-1:0] s_od;
  logic [1:0]   s_occ;

  logic [W-1:0] exp_q[$];

  treg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, sample outputs mid-cycle, then cross the edge.
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic orr, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    flush     = fl;
    @(negedge clk);
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_od  = out_data;
    s_occ = occupancy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 10'h0AA, 1'b1, 1'b0);
      total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", s_ir); end
    end
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", s_ov); end
    total++; if (s_od !== 10'h000) begin bad++; $display("FAIL reset_out_data got=%h want=000", s_od); end
    total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", s_occ); end
    total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", s_ir); end
  endtask

  // Words 1..5 accepted in cycles 0..4 appear in cycles 3..7.
  task automatic test_stream();
    int peak = 0;
    for (int j = 0; j < 10; j++) begin
      logic       e_ov;
      logic [1:0] e_occ;
      cyc(j < 5, W'(j + 1), 1'b1, 1'b0);
      e_ov  = (j >= 3 && j <= 7);
      e_occ = (j <= 3) ? 2'(j) : (j <= 5) ? 2'd3 : (j <= 8) ? 2'(8 - j) : 2'd0;
      if (int'(s_occ) > peak) peak = int'(s_occ);
      total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL stream_in_ready cyc=%0d got=%b want=1", j, s_ir); end
      total++; if (s_ov !== e_ov) begin bad++; $display("FAIL stream_out_valid cyc=%0d got=%b want=%b", j, s_ov, e_ov); end
      total++; if (s_occ !== e_occ) begin bad++; $display("FAIL stream_occ cyc=%0d got=%0d want=%0d", j, s_occ, e_occ); end
      if (e_ov) begin
        total++; if (s_od !== W'(j - 2)) begin bad++; $display("FAIL stream_out_data cyc=%0d got=%h want=%h", j, s_od, W'(j - 2)); end
      end
    end
    total++; if (peak != 3) begin bad++; $display("FAIL stream_peak got=%0d want=3", peak); end
  endtask

  task automatic test_stall();
    logic [W-1:0] w [3];
    w[0] = 10'h3FF; w[1] = 10'h155; w[2] = 10'h2AA;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, w[i], 1'b0, 1'b0);
      total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL stall_fill_in_ready i=%0d got=%b want=1", i, s_ir); end
    end
    // Full and stalled: upstream word 0x111 must not be captured.
    for (int h = 0; h < 4; h++) begin
      cyc(1'b1, 10'h111, 1'b0, 1'b0);
      total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL stall_in_ready h=%0d got=%b want=0", h, s_ir); end
      total++; if (s_occ !== 2'd3) begin bad++; $display("FAIL stall_occ h=%0d got=%0d want=3", h, s_occ); end
      total++; if (s_ov !== 1'b1) begin bad++; $display("FAIL stall_out_valid h=%0d got=%b want=1", h, s_ov); end
      total++; if (s_od !== 10'h3FF) begin bad++; $display("FAIL stall_out_data h=%0d got=%h want=3ff", h, s_od); end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      total++; if (s_ov !== 1'b1) begin bad++; $display("FAIL stall_drain_valid k=%0d got=%b want=1", k, s_ov); end
      total++; if (s_od !== w[k]) begin bad++; $display("FAIL stall_drain_data k=%0d got=%h want=%h", k, s_od, w[k]); end
      total++; if (s_occ !== 2'(3 - k)) begin bad++; $display("FAIL stall_drain_occ k=%0d got=%0d want=%0d", k, s_occ, 3 - k); end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL stall_empty_valid got=%b want=0", s_ov); end
    total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL stall_empty_occ got=%0d want=0", s_occ); end
  endtask

  // Full pipe with both sides ready: one in and one out every cycle.
  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) cyc(1'b1, W'(10'h100 + f), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, W'(10'h103 + k), 1'b1, 1'b0);
      total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b want=1", k, s_ir); end
      total++; if (s_ov !== 1'b1) begin bad++; $display("FAIL b2b_out_valid k=%0d got=%b want=1", k, s_ov); end
      total++; if (s_od !== W'(10'h100 + k)) begin bad++; $display("FAIL b2b_out_data k=%0d got=%h want=%h", k, s_od, W'(10'h100 + k)); end
      total++; if (s_occ !== 2'd3) begin bad++; $display("FAIL b2b_occ k=%0d got=%0d want=3", k, s_occ); end
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      total++; if (s_od !== W'(10'h10A + k)) begin bad++; $display("FAIL b2b_drain_data k=%0d got=%h want=%h", k, s_od, W'(10'h10A + k)); end
      total++; if (s_occ !== 2'(3 - k)) begin bad++; $display("FAIL b2b_drain_occ k=%0d got=%0d want=%0d", k, s_occ, 3 - k); end
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL b2b_empty_valid got=%b want=0", s_ov); end
  endtask

  task automatic test_flush();
    cyc(1'b1, 10'h0A1, 1'b0, 1'b0);
    cyc(1'b1, 10'h0A2, 1'b0, 1'b0);
    cyc(1'b1, 10'h3C3, 1'b0, 1'b1);
    total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", s_ir); end
    total++; if (s_occ !== 2'd2) begin bad++; $display("FAIL flush_occ_before got=%0d want=2", s_occ); end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL flush_out_valid k=%0d got=%b want=0", k, s_ov); end
      total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL flush_occ k=%0d got=%0d want=0", k, s_occ); end
    end
  endtask

  task automatic test_reset_flight();
    cyc(1'b1, 10'h0B1, 1'b0, 1'b0);
    cyc(1'b1, 10'h0B2, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 10'h0B3, 1'b1, 1'b1);
    total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL rstf_in_ready0 got=%b want=0", s_ir); end
    cyc(1'b1, 10'h0B4, 1'b1, 1'b1);
    total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL rstf_out_valid got=%b want=0", s_ov); end
    total++; if (s_od !== 10'h000) begin bad++; $display("FAIL rstf_out_data got=%h want=000", s_od); end
    total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL rstf_occ got=%0d want=0", s_occ); end
    total++; if (s_ir !== 1'b0) begin bad++; $display("FAIL rstf_in_ready1 got=%b want=0", s_ir); end
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++; if (s_ov !== 1'b0) begin bad++; $display("FAIL rstf_rel_valid got=%b want=0", s_ov); end
    total++; if (s_ir !== 1'b1) begin bad++; $display("FAIL rstf_rel_in_ready got=%b want=1", s_ir); end
  endtask

  // Random handshakes against the scoreboard queue.
  task automatic test_random();
    int           sent = 0;
    int           got  = 0;
    int           n    = 0;
    logic [W-1:0] w    = W'($urandom_range(0, 1023));
    logic         iv;
    logic         orr;
    logic         e_ir;
    logic [W-1:0] e_d;
    exp_q.delete();
    while (got < 2000 && n < 30000) begin
      iv  = (sent < 2000) && ($urandom_range(0, 1) == 1);
      orr = ($urandom_range(0, 1) == 1);
      cyc(iv, w, orr, 1'b0);
      e_ir = (exp_q.size() < D) || orr;
      total++; if (s_ir !== e_ir) begin bad++; $display("FAIL rand_in_ready n=%0d got=%b want=%b", n, s_ir, e_ir); end
      total++; if (int'(s_occ) != exp_q.size()) begin bad++; $display("FAIL rand_occ n=%0d got=%0d want=%0d", n, s_occ, exp_q.size()); end
      if (s_ov && orr) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra_word n=%0d got=%h want=none", n, s_od);
        end else begin
          e_d = exp_q.pop_front();
          if (s_od !== e_d) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, s_od, e_d); end
        end
        got++;
      end
      if (iv && s_ir) begin
        exp_q.push_back(w);
        sent++;
        w = W'($urandom_range(0, 1023));
      end
      n++;
    end
    total++; if (got < 2000) begin bad++; $display("FAIL rand_timeout got=%0d want=2000", got); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
